spr_rom_arbiter: RTL and testbench

- Shares one 32-bit graphics-ROM memory port between three clients: the sprite fetch path (k051960 CA address → 32-bit chunky data for k051937), the tile-layer fetch path, and the MiSTer ROM loader.
- Sits between the sprite/tile layer modules and the SDRAM controller.
- Sequences one transaction at a time with a req/ack handshake on every side.
- Sprite has fixed priority over tile, with a starvation guard; the loader owns the port exclusively while load_en is high.

---
 rtl/spr_rom_arb_pkg.sv | 26 ++
 rtl/spr_rom_arb_grant.sv | 69 ++++++
 rtl/spr_rom_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_spr_rom_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spr_rom_arb_pkg.sv
// Shared types and constants for the graphics-ROM port arbiter.
package spr_rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CL_NONE = 2'd0,
    CL_SPR  = 2'd1,
    CL_TILE = 2'd2,
    CL_LD   = 2'd3
  } client_e;

  localparam logic [3:0] BE_LO  = 4'h3;
  localparam logic [3:0] BE_HI  = 4'hC;
  localparam logic [3:0] BE_ALL = 4'hF;

  // Loader halfword lands in the low or high half of the 32-bit word.
  function automatic logic [3:0] ld_be(input logic half_sel);
    return half_sel ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/spr_rom_arb_grant.sv
// Priority selection between loader, sprite and tile plus the tile starvation counter.
module spr_rom_arb_grant
  import spr_rom_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
)
(
  input  logic    clk,
  input  logic    reset,
  input  logic    idle_i,
  input  logic    load_en_i,
  input  logic    ld_pending_i,
  input  logic    spr_req_i,
  input  logic    spr_hit_i,
  input  logic    tile_req_i,
  output client_e grant_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q;
  logic [7:0] starve_d;
  client_e    grant_s;

  // A pending write always drains first, even once load_en has dropped.
  always_comb begin
    grant_s = CL_NONE;
    if (!idle_i) begin
      grant_s = CL_NONE;
    end else if (ld_pending_i) begin
      grant_s = CL_LD;
    end else if (load_en_i) begin
      grant_s = CL_NONE;
    end else if (tile_req_i && (starve_q >= LIMIT)) begin
      grant_s = CL_TILE;
    end else if (spr_req_i) begin
      grant_s = CL_SPR;
    end else if (tile_req_i) begin
      grant_s = CL_TILE;
    end else begin
      grant_s = CL_NONE;
    end
  end

  // Cache hits never touch memory, so they do not count against the tile.
  always_comb begin
    starve_d = starve_q;
    if (!tile_req_i) begin
      starve_d = 8'd0;
    end else if (grant_s == CL_TILE) begin
      starve_d = 8'd0;
    end else if ((grant_s == CL_SPR) && !spr_hit_i && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign grant_o = grant_s;

endmodule

// File: rtl/spr_rom_arbiter.sv
// Shares one 32-bit graphics-ROM port between sprite fetch, tile fetch and the ROM loader.
// Optional sprite hit cache enabled by defining SPR_ROM_ARB_HITCACHE_EN.
module spr_rom_arbiter
  import spr_rom_arb_pkg::*;
#(
  parameter int unsigned   AW           = 24,
  parameter logic [AW-1:0] SPR_BASE     = 24'h000000,
  parameter logic [AW-1:0] TILE_BASE    = 24'h080000,
  parameter int unsigned   STARVE_LIMIT = 8
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic          ld_we,
  input  logic [25:0]   ld_addr,
  input  logic [15:0]   ld_data,
  output logic          ld_busy,
  input  logic          spr_req,
  input  logic [18:0]   spr_addr,
  output logic [31:0]   spr_dout,
  output logic          spr_ack,
  input  logic          tile_req,
  input  logic [19:0]   tile_addr,
  output logic [31:0]   tile_dout,
  output logic          tile_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  state_e        state_q;
  client_e       client_q;
  client_e       grant_s;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   spr_dout_q;
  logic [31:0]   tile_dout_q;
  logic          spr_ack_q;
  logic          tile_ack_q;
  logic          ld_busy_q;
  logic          ld_pending_q;
  logic [25:1]   ld_addr_q;
  logic [15:0]   ld_data_q;

  logic [AW-1:0] spr_maddr_s;
  logic [AW-1:0] tile_maddr_s;
  logic [AW-1:0] ld_maddr_s;
  logic          spr_hit_s;
  logic [31:0]   cache_data_s;
  logic          unused_s;

  // Sums wrap naturally at AW bits.
  assign spr_maddr_s  = SPR_BASE + AW'(spr_addr);
  assign tile_maddr_s = TILE_BASE + AW'(tile_addr);
  assign ld_maddr_s   = AW'(ld_addr_q[25:2]);
  assign unused_s     = ld_addr[0];

  spr_rom_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk          (clk),
    .reset        (reset),
    .idle_i       (state_q == ST_IDLE),
    .load_en_i    (load_en),
    .ld_pending_i (ld_pending_q),
    .spr_req_i    (spr_req),
    .spr_hit_i    (spr_hit_s),
    .tile_req_i   (tile_req),
    .grant_o      (grant_s)
  );

`ifdef SPR_ROM_ARB_HITCACHE_EN
  logic [AW-1:0] cache_addr_q;
  logic [31:0]   cache_data_q;
  logic          cache_vld_q;

  // Remember the last sprite word fetched; a write to that word invalidates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_addr_q <= {AW{1'b0}};
      cache_data_q <= 32'd0;
      cache_vld_q  <= 1'b0;
    end else if ((state_q == ST_BUSY) && mem_ack && (client_q == CL_SPR)) begin
      cache_addr_q <= mem_addr_q;
      cache_data_q <= mem_rdata;
      cache_vld_q  <= 1'b1;
    end else if ((grant_s == CL_LD) && (ld_maddr_s == cache_addr_q)) begin
      cache_vld_q  <= 1'b0;
    end else begin
      cache_vld_q  <= cache_vld_q;
    end
  end

  assign spr_hit_s    = cache_vld_q && (cache_addr_q == spr_maddr_s);
  assign cache_data_s = cache_data_q;
`else
  assign spr_hit_s    = 1'b0;
  assign cache_data_s = 32'd0;
`endif

  // Transaction sequencer: grant in IDLE, wait for mem_ack in BUSY, acknowledge in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      client_q     <= CL_NONE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'd0;
      spr_dout_q   <= 32'd0;
      tile_dout_q  <= 32'd0;
      spr_ack_q    <= 1'b0;
      tile_ack_q   <= 1'b0;
      ld_busy_q    <= 1'b0;
      ld_pending_q <= 1'b0;
      ld_addr_q    <= 25'd0;
      ld_data_q    <= 16'd0;
    end else begin
      spr_ack_q  <= 1'b0;
      tile_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          client_q <= grant_s;
          case (grant_s)
            CL_SPR: begin
              if (spr_hit_s) begin
                spr_dout_q <= cache_data_s;
                spr_ack_q  <= 1'b1;
                state_q    <= ST_DONE;
              end else begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= spr_maddr_s;
                mem_be_q    <= BE_ALL;
                mem_wdata_q <= {ld_data_q, ld_data_q};
                state_q     <= ST_BUSY;
              end
            end
            CL_TILE: begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= tile_maddr_s;
              mem_be_q    <= BE_ALL;
              mem_wdata_q <= {ld_data_q, ld_data_q};
              state_q     <= ST_BUSY;
            end
            CL_LD: begin
              mem_req_q    <= 1'b1;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= ld_maddr_s;
              mem_be_q     <= ld_be(ld_addr_q[1]);
              mem_wdata_q  <= {ld_data_q, ld_data_q};
              ld_pending_q <= 1'b0;
              state_q      <= ST_BUSY;
            end
            default: begin
              state_q <= ST_IDLE;
            end
          endcase
        end
        ST_BUSY: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            case (client_q)
              CL_SPR: begin
                spr_dout_q <= mem_rdata;
                spr_ack_q  <= spr_req;
              end
              CL_TILE: begin
                tile_dout_q <= mem_rdata;
                tile_ack_q  <= tile_req;
              end
              default: begin
                spr_ack_q <= 1'b0;
              end
            endcase
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          // A write captured during this one keeps the loader busy.
          if (client_q == CL_LD) begin
            ld_busy_q <= ld_pending_q;
          end else begin
            ld_busy_q <= ld_busy_q;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Loader capture is accepted in any state and overrides same-cycle clears.
      if (ld_we) begin
        ld_pending_q <= 1'b1;
        ld_busy_q    <= 1'b1;
        ld_addr_q    <= ld_addr[25:1];
        ld_data_q    <= ld_data;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign spr_dout  = spr_dout_q;
  assign spr_ack   = spr_ack_q;
  assign tile_dout = tile_dout_q;
  assign tile_ack  = tile_ack_q;
  assign ld_busy   = ld_busy_q;

endmodule

// File: tb/tb_spr_rom_arbiter.sv
// Scoreboard bench for spr_rom_arbiter with a latency-2 memory responder.
module tb_spr_rom_arbiter;
  import spr_rom_arb_pkg::*;

  localparam int ACK_DLY = 2;
  localparam logic [23:0] SPR_BASE_TB  = 24'h000000;
  localparam logic [23:0] TILE_BASE_TB = 24'h080000;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [23:0] addr;
    logic [31:0] wd;
  } txn_t;

  logic clk, reset, load_en, ld_we, ld_busy;
  logic [25:0] ld_addr;
  logic [15:0] ld_data;
  logic spr_req, spr_ack, tile_req, tile_ack;
  logic [18:0] spr_addr;
  logic [19:0] tile_addr;
  logic [31:0] spr_dout, tile_dout;
  logic mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  logic w_tile_req, w_tile_ack, w_mem_req, w_mem_we, w_mem_ack, w_ld_busy, w_spr_ack;
  logic [19:0] w_tile_addr;
  logic [31:0] w_tile_dout, w_spr_dout, w_mem_wdata, w_mem_rdata;
  logic [23:0] w_mem_addr;
  logic [3:0]  w_mem_be;

  int checks = 0;
  int failures = 0;
  logic resp_en, stray_pend, in_flight;
  int cnt;
  txn_t txn_q[$];
  logic [31:0] spr_exp_q[$];
  logic [31:0] tile_exp_q[$];

  spr_rom_arbiter dut (
    .clk(clk), .reset(reset), .load_en(load_en), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_busy(ld_busy), .spr_req(spr_req), .spr_addr(spr_addr),
    .spr_dout(spr_dout), .spr_ack(spr_ack), .tile_req(tile_req), .tile_addr(tile_addr),
    .tile_dout(tile_dout), .tile_ack(tile_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  spr_rom_arbiter #(.TILE_BASE(24'hFFFFFF)) dut_w (
    .clk(clk), .reset(reset), .load_en(1'b0), .ld_we(1'b0), .ld_addr(26'd0),
    .ld_data(16'd0), .ld_busy(w_ld_busy), .spr_req(1'b0), .spr_addr(19'd0),
    .spr_dout(w_spr_dout), .spr_ack(w_spr_ack), .tile_req(w_tile_req), .tile_addr(w_tile_addr),
    .tile_dout(w_tile_dout), .tile_ack(w_tile_ack), .mem_req(w_mem_req), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack),
    .mem_rdata(w_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mdata(input logic [23:0] a);
    return (a == 24'h000123) ? 32'hDEADBEEF : {8'h5A, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: logs every new transaction and acks ACK_DLY cycles after mem_req.
  initial begin
    mem_ack = 1'b0; mem_rdata = 32'd0; in_flight = 1'b0; cnt = 0;
    forever begin
      tick();
      if (mem_ack) begin
        mem_ack = 1'b0;
        in_flight = 1'b0;
      end else if (!resp_en) begin
        in_flight = 1'b0;
        if (stray_pend) begin
          mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; stray_pend = 1'b0;
        end
      end else if (reset) begin
        in_flight = 1'b0;
      end else if (mem_req && !in_flight) begin
        in_flight = 1'b1;
        cnt = ACK_DLY;
        txn_q.push_back('{we: mem_we, be: mem_be, addr: mem_addr, wd: mem_wdata});
      end else if (in_flight) begin
        if (cnt > 0) cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mdata(mem_addr);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    txn_q.delete();
  endtask

  task automatic spr_txn(input logic [18:0] a, output logic acked, output int lat);
    spr_exp_q.push_back(mdata(SPR_BASE_TB + 24'(a)));
    spr_addr = a; spr_req = 1'b1; acked = 1'b0; lat = 0;
    while (!acked && lat < 40) begin
      tick(); lat++;
      if (spr_ack === 1'b1) acked = 1'b1;
    end
    spr_req = 1'b0;
  endtask

  task automatic wait_ld_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (ld_busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_we, spr_ack, tile_ack, ld_busy} !== 5'b0) begin
      failures++; $display("FAIL reset_ctl: got %b expected 00000", {mem_req, mem_we, spr_ack, tile_ack, ld_busy});
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, spr_dout, tile_dout} !== 124'd0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_be, mem_wdata, spr_dout, tile_dout});
    end
  endtask

  task automatic test_spr_read();
    logic acked; int lat; logic [31:0] exp;
    do_reset();
    spr_txn(19'h00123, acked, lat);
    exp = spr_exp_q.pop_front();
    checks++;
    if (!acked || spr_dout !== exp) begin
      failures++; $display("FAIL spr_read_data: got %h ack %b expected %h", spr_dout, acked, exp);
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL spr_read_latency: got %0d expected 4", lat);
    end
    checks++;
    if (txn_q.size() != 1 || txn_q[0] !== '{we: 1'b0, be: 4'hF, addr: 24'h000123, wd: 32'd0}) begin
      failures++; $display("FAIL spr_read_mem: got %0d txns first %h expected 0F00012300000000", txn_q.size(), txn_q.size() ? txn_q[0] : '0);
    end
    tick();
    checks++;
    if ({spr_ack, tile_ack, tile_dout} !== 34'd0) begin
      failures++; $display("FAIL spr_read_after: got ack %b tile %b/%h expected 0", spr_ack, tile_ack, tile_dout);
    end
  endtask

  task automatic test_tile_read();
    logic acked; logic [31:0] exp;
    do_reset();
    tile_exp_q.push_back(mdata(TILE_BASE_TB + 24'h000042));
    tile_addr = 20'h00042; tile_req = 1'b1; acked = 1'b0;
    for (int i = 0; i < 40 && !acked; i++) begin
      tick();
      if (tile_ack === 1'b1) acked = 1'b1;
    end
    tile_req = 1'b0;
    exp = tile_exp_q.pop_front();
    checks++;
    if (!acked || tile_dout !== exp || txn_q.size() != 1 || txn_q[0].addr !== 24'h080042) begin
      failures++; $display("FAIL tile_read: got %h ack %b expected %h at 080042", tile_dout, acked, exp);
    end
  endtask

  task automatic test_arbitration();
    int spr_acks; logic tile_done; int bad;
    do_reset();
    spr_addr = 19'h00010; tile_addr = 20'h00020;
    spr_req = 1'b1; tile_req = 1'b1; spr_acks = 0; tile_done = 1'b0; bad = 0;
    for (int i = 0; i < 300 && !tile_done; i++) begin
      tick();
      if (txn_q.size() >= 9) spr_req = 1'b0;
      if (spr_ack === 1'b1) begin
        spr_acks++;
        if (spr_dout !== mdata(24'h000010)) bad++;
      end
      if (tile_ack === 1'b1) begin
        tile_done = 1'b1; tile_req = 1'b0;
      end
    end
    spr_req = 1'b0;
    for (int i = 0; i < 8 && i < txn_q.size(); i++) if (txn_q[i].addr !== 24'h000010) bad++;
    checks++;
    if (spr_acks != 8 || bad != 0) begin
      failures++; $display("FAIL arb_sprite_wins: got %0d acks %0d bad expected 8 acks 0 bad", spr_acks, bad);
    end
    checks++;
    if (!tile_done || txn_q.size() != 9 || txn_q[8].addr !== 24'h080020 || tile_dout !== mdata(24'h080020)) begin
      failures++; $display("FAIL arb_ninth_tile: got done %b txns %0d expected tile at 080020", tile_done, txn_q.size());
    end
    tick();
    checks++;
    if (dut.u_grant.starve_q !== 8'd0) begin
      failures++; $display("FAIL arb_counter: got %0d expected 0", dut.u_grant.starve_q);
    end
  endtask

  task automatic test_load();
    logic ok; logic acked;
    do_reset();
    load_en = 1'b1; spr_addr = 19'h00077; spr_req = 1'b1; acked = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (txn_q.size() != 0) begin
      failures++; $display("FAIL load_stall: got %0d txns expected 0", txn_q.size());
    end
    ld_addr = 26'h0000006; ld_data = 16'hA55A; ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
    checks++;
    if (ld_busy !== 1'b1) begin
      failures++; $display("FAIL load_busy: got %b expected 1", ld_busy);
    end
    wait_ld_idle(ok);
    checks++;
    if (!ok || txn_q.size() != 1 || txn_q[0] !== '{we: 1'b1, be: 4'hC, addr: 24'h000001, wd: 32'hA55AA55A}) begin
      failures++; $display("FAIL load_write_hi: got ok %b txns %0d first %h expected 1C000001A55AA55A", ok, txn_q.size(), txn_q.size() ? txn_q[0] : '0);
    end
    ld_addr = 26'h0000008; ld_data = 16'h1234; ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
    wait_ld_idle(ok);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (spr_ack === 1'b1) acked = 1'b1;
    end
    checks++;
    if (!ok || acked || txn_q.size() != 2 || txn_q[1] !== '{we: 1'b1, be: 4'h3, addr: 24'h000002, wd: 32'h12341234}) begin
      failures++; $display("FAIL load_write_lo: got ok %b sprack %b txns %0d expected 1 0 2", ok, acked, txn_q.size());
    end
    load_en = 1'b0;
    for (int i = 0; i < 40 && !acked; i++) begin
      tick();
      if (spr_ack === 1'b1) acked = 1'b1;
    end
    spr_req = 1'b0;
    checks++;
    if (!acked || spr_dout !== mdata(24'h000077) || txn_q.size() != 3 || txn_q[2].we !== 1'b0) begin
      failures++; $display("FAIL load_resume: got ack %b data %h txns %0d expected sprite read", acked, spr_dout, txn_q.size());
    end
  endtask

  task automatic test_load_fall();
    logic acked; int lat; logic [31:0] exp;
    do_reset();
    load_en = 1'b1; ld_addr = 26'h0000010; ld_data = 16'h0F0F; ld_we = 1'b1;
    tick();
    ld_we = 1'b0; load_en = 1'b0;
    spr_txn(19'h00003, acked, lat);
    exp = spr_exp_q.pop_front();
    checks++;
    if (!acked || spr_dout !== exp || txn_q.size() != 2 || txn_q[0].we !== 1'b1 || txn_q[1].we !== 1'b0) begin
      failures++; $display("FAIL load_fall_order: got ack %b txns %0d expected write then read", acked, txn_q.size());
    end
  endtask

  task automatic test_abandon();
    logic seen; logic acked;
    do_reset();
    spr_addr = 19'h00055; spr_req = 1'b1; seen = 1'b0; acked = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_req === 1'b1) seen = 1'b1;
    end
    spr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (spr_ack === 1'b1) acked = 1'b1;
    end
    checks++;
    if (!seen || acked || spr_dout !== mdata(24'h000055)) begin
      failures++; $display("FAIL abandon: got req %b ack %b data %h expected 1 0 %h", seen, acked, spr_dout, mdata(24'h000055));
    end
  endtask

  task automatic test_reset_mid_busy();
    logic seen; logic bad;
    do_reset();
    resp_en = 1'b0;
    spr_addr = 19'h00009; spr_req = 1'b1; seen = 1'b0; bad = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_req === 1'b1) seen = 1'b1;
    end
    reset = 1'b1; spr_req = 1'b0;
    tick();
    reset = 1'b0; stray_pend = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (spr_ack !== 1'b0 || tile_ack !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (!seen || bad || stray_pend) begin
      failures++; $display("FAIL reset_busy_acks: got req %b bad %b stray %b expected 1 0 0", seen, bad, stray_pend);
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, spr_dout, tile_dout, ld_busy, mem_we} !== 126'd0 || dut.state_q !== ST_IDLE) begin
      failures++; $display("FAIL reset_busy_state: got %h state %0d expected 0 IDLE", {mem_addr, mem_be, mem_wdata, spr_dout}, dut.state_q);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_hitcache();
    logic acked; int lat; logic ok; logic [31:0] exp;
    do_reset();
    spr_txn(19'h00005, acked, lat);
    exp = spr_exp_q.pop_front();
    tick();
    spr_txn(19'h00005, acked, lat);
    exp = spr_exp_q.pop_front();
`ifdef SPR_ROM_ARB_HITCACHE_EN
    checks++;
    if (!acked || spr_dout !== exp || txn_q.size() != 1 || lat > 2) begin
      failures++; $display("FAIL hit_reuse: got ack %b data %h txns %0d lat %0d expected 1 %h 1 <=2", acked, spr_dout, txn_q.size(), lat, exp);
    end
    load_en = 1'b1; ld_addr = 26'h0000014; ld_data = 16'h7777; ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
    wait_ld_idle(ok);
    load_en = 1'b0;
    spr_txn(19'h00005, acked, lat);
    exp = spr_exp_q.pop_front();
    checks++;
    if (!ok || !acked || txn_q.size() != 3 || txn_q[2].addr !== 24'h000005 || txn_q[2].we !== 1'b0) begin
      failures++; $display("FAIL hit_invalidate: got ok %b ack %b txns %0d expected fresh read", ok, acked, txn_q.size());
    end
`else
    checks++;
    if (!acked || spr_dout !== exp || txn_q.size() != 2) begin
      failures++; $display("FAIL nocache_reads: got ack %b data %h txns %0d expected 1 %h 2", acked, spr_dout, txn_q.size(), exp);
    end
`endif
  endtask

  task automatic test_wrap();
    logic seen; logic acked;
    seen = 1'b0; acked = 1'b0;
    w_tile_addr = 20'h00002; w_tile_req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (w_mem_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || w_mem_addr !== 24'h000001) begin
      failures++; $display("FAIL wrap_addr: got req %b addr %h expected 000001", seen, w_mem_addr);
    end
    w_mem_rdata = 32'h12345678; w_mem_ack = 1'b1;
    tick();
    w_mem_ack = 1'b0;
    if (w_tile_ack === 1'b1) acked = 1'b1;
    for (int i = 0; i < 5 && !acked; i++) begin
      tick();
      if (w_tile_ack === 1'b1) acked = 1'b1;
    end
    w_tile_req = 1'b0;
    checks++;
    if (!acked || w_tile_dout !== 32'h12345678) begin
      failures++; $display("FAIL wrap_data: got ack %b data %h expected 1 12345678", acked, w_tile_dout);
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; ld_we = 1'b0; ld_addr = 26'd0; ld_data = 16'd0;
    spr_req = 1'b0; spr_addr = 19'd0; tile_req = 1'b0; tile_addr = 20'd0;
    w_tile_req = 1'b0; w_tile_addr = 20'd0; w_mem_ack = 1'b0; w_mem_rdata = 32'd0;
    resp_en = 1'b1; stray_pend = 1'b0;
    tick(); tick();
    test_reset();
    test_spr_read();
    test_tile_read();
    test_arbitration();
    test_load();
    test_load_fall();
    test_abandon();
    test_reset_mid_busy();
    test_hitcache();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
